// File: rtl/pkt_hexdump_pkg.sv
//------------------------------------------------------------------
// pkt_hexdump_pkg: dump FSM states, ASCII codes, hex lookup. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

package pkt_hexdump_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_HDR   = 4'd1,
    S_OFFS  = 4'd2,
    S_SEP   = 4'd3,
    S_HEXHI = 4'd4,
    S_HEXLO = 4'd5,
    S_SPACE = 4'd6,
    S_CR    = 4'd7,
    S_LF    = 4'd8,
    S_GAP   = 4'd9
  } dump_state_t;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_P     = 8'h50;

  // Lowercase hex digit: '0'..'9' then 'a'..'f'.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

endpackage

`default_nettype wire

// File: rtl/pkt_desc_fifo.sv
//------------------------------------------------------------------
// pkt_desc_fifo: synchronous FIFO of packet-length words. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module pkt_desc_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;

  // Extra pointer bit separates full from empty when the indices match.
  assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty    = (wp == rp);
  assign pop_data = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pkt_hexdump.sv
//------------------------------------------------------------------
// pkt_hexdump: buffers packets and dumps them as ASCII hex to a UART. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module pkt_hexdump
  import pkt_hexdump_pkg::*;
#(
  parameter int IN_W           = 8,
  parameter int BUF_DEPTH      = 2048,
  parameter int DESC_DEPTH     = 16,
  parameter int BYTES_PER_LINE = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_last,
  output logic            tx_dv,
  output logic [7:0]      tx_byte,
  input  logic            tx_active,
  output logic            busy,
  output logic [7:0]      drop_cnt,
  output logic            overflow
);

  localparam int         AW     = $clog2(BUF_DEPTH);
  localparam int         LW     = AW + 1;
  localparam logic [6:0] LINE_N = 7'(BYTES_PER_LINE);

  logic          byte_valid;
  logic          byte_last;
  logic [7:0]    byte_data;

  logic [LW-1:0] wr_spec;
  logic [LW-1:0] wr_commit;
  logic [LW-1:0] rd_ptr;
  logic [LW-1:0] cur_len;
  logic [LW-1:0] desc_len;
  logic [LW-1:0] pop_len;
  logic          discard;
  logic          buf_full;
  logic          accept;
  logic          drop_now;
  logic          desc_push;
  logic          desc_pop;
  logic          desc_full;
  logic          desc_empty;

  logic [7:0]    mem [BUF_DEPTH];
  logic [7:0]    rd_data;
  logic [AW-1:0] rd_addr;

  dump_state_t   state;
  logic [1:0]    step;
  logic [1:0]    last_step;
  logic [1:0]    hs;
  logic [LW-1:0] pkt_len;
  logic [LW-1:0] byte_idx;
  logic [6:0]    line_cnt;
  logic [7:0]    seq;
  logic          hdr_line;
  logic [7:0]    ch;
  logic [15:0]   offs;
  logic [3:0]    offs_nib;

  generate
    if (IN_W == 4) begin : g_nibble
      logic       phase;
      logic [3:0] low_nib;

      always_ff @(posedge clk) begin
        if (reset) begin
          phase   <= 1'b0;
          low_nib <= 4'h0;
        end else if (in_valid) begin
          phase   <= ~phase & ~in_last;
          low_nib <= in_data[3:0];
        end
      end

      // A lone trailing nibble closes the packet as a zero-padded byte.
      assign byte_valid = in_valid & (phase | in_last);
      assign byte_last  = in_last;
      assign byte_data  = phase ? {in_data[3:0], low_nib} : {4'h0, in_data[3:0]};
    end else begin : g_byte
      assign byte_valid = in_valid;
      assign byte_last  = in_last;
      assign byte_data  = in_data[7:0];
    end
  endgenerate

  assign buf_full  = (wr_spec[AW] != rd_ptr[AW]) && (wr_spec[AW-1:0] == rd_ptr[AW-1:0]);
  assign accept    = byte_valid & ~discard & ~buf_full & ~(byte_last & desc_full);
  assign drop_now  = byte_valid & ~discard & ~accept;
  assign desc_push = accept & byte_last;
  assign desc_len  = cur_len + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_spec   <= '0;
      wr_commit <= '0;
      cur_len   <= '0;
      discard   <= 1'b0;
      drop_cnt  <= 8'h00;
      overflow  <= 1'b0;
    end else begin
      if (accept) begin
        wr_spec <= wr_spec + 1'b1;
        if (byte_last) begin
          wr_commit <= wr_spec + 1'b1;
          cur_len   <= '0;
        end else begin
          cur_len <= cur_len + 1'b1;
        end
      end
      if (drop_now) begin
        wr_spec  <= wr_commit;
        cur_len  <= '0;
        discard  <= ~byte_last;
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      end else if (byte_valid && discard && byte_last) begin
        discard <= 1'b0;
      end
    end
  end

  // Byte storage is deliberately left uninitialised by reset.
  assign rd_addr = rd_ptr[AW-1:0] + byte_idx[AW-1:0];

  always_ff @(posedge clk) begin
    if (accept) mem[wr_spec[AW-1:0]] <= byte_data;
    rd_data <= mem[rd_addr];
  end

  pkt_desc_fifo #(
    .WIDTH (LW),
    .DEPTH (DESC_DEPTH)
  ) u_desc_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (desc_push),
    .push_data (desc_len),
    .pop       (desc_pop),
    .pop_data  (pop_len),
    .full      (desc_full),
    .empty     (desc_empty)
  );

  assign desc_pop = (state == S_IDLE) & ~desc_empty;
  assign busy     = ~desc_empty | (state != S_IDLE);
  assign offs     = 16'(byte_idx);

  always_comb begin
    case (step)
      2'd0:    offs_nib = offs[15:12];
      2'd1:    offs_nib = offs[11:8];
      2'd2:    offs_nib = offs[7:4];
      default: offs_nib = offs[3:0];
    endcase
    ch        = 8'h00;
    last_step = 2'd0;
    case (state)
      S_HDR: begin
        last_step = 2'd2;
        case (step)
          2'd0:    ch = ASCII_P;
          2'd1:    ch = hex_char(seq[7:4]);
          default: ch = hex_char(seq[3:0]);
        endcase
      end
      S_OFFS: begin
        last_step = 2'd3;
        ch        = hex_char(offs_nib);
      end
      S_SEP: begin
        last_step = 2'd1;
        ch        = (step == 2'd0) ? ASCII_COLON : ASCII_SPACE;
      end
      S_HEXHI: ch = hex_char(rd_data[7:4]);
      S_HEXLO: ch = hex_char(rd_data[3:0]);
      S_SPACE: ch = ASCII_SPACE;
      S_CR:    ch = ASCII_CR;
      S_LF:    ch = ASCII_LF;
      S_GAP: begin
        last_step = 2'd1;
        ch        = (step == 2'd0) ? ASCII_CR : ASCII_LF;
      end
      default: ch = 8'h00;
    endcase
  end

  // hs: 0 = may issue, 1 = waiting for tx_active high, 2 = waiting for it to drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      step     <= 2'd0;
      hs       <= 2'd0;
      tx_dv    <= 1'b0;
      tx_byte  <= 8'h00;
      pkt_len  <= '0;
      byte_idx <= '0;
      line_cnt <= 7'd0;
      seq      <= 8'h00;
      hdr_line <= 1'b0;
      rd_ptr   <= '0;
    end else begin
      tx_dv <= 1'b0;
      if (state == S_IDLE) begin
        if (!desc_empty) begin
          state    <= S_HDR;
          pkt_len  <= pop_len;
          byte_idx <= '0;
          line_cnt <= 7'd0;
          hdr_line <= 1'b1;
          step     <= 2'd0;
          hs       <= 2'd0;
        end
      end else begin
        case (hs)
          2'd0: if (!tx_active) begin
            tx_dv   <= 1'b1;
            tx_byte <= ch;
            hs      <= 2'd1;
          end
          2'd1: if (tx_active) hs <= 2'd2;
          default: if (!tx_active) begin
            hs <= 2'd0;
            if (step != last_step) begin
              step <= step + 1'b1;
            end else begin
              step <= 2'd0;
              case (state)
                S_HDR:   state <= S_CR;
                S_OFFS:  state <= S_SEP;
                S_SEP:   state <= S_HEXHI;
                S_HEXHI: state <= S_HEXLO;
                // Advancing here gives the RAM the whole SPACE character to fetch the next byte.
                S_HEXLO: begin
                  state    <= S_SPACE;
                  byte_idx <= byte_idx + 1'b1;
                  line_cnt <= line_cnt + 1'b1;
                end
                S_SPACE: state <= (byte_idx == pkt_len || line_cnt == LINE_N) ? S_CR : S_HEXHI;
                S_CR:    state <= S_LF;
                S_LF: begin
                  hdr_line <= 1'b0;
                  line_cnt <= 7'd0;
                  state    <= (!hdr_line && byte_idx == pkt_len) ? S_GAP : S_OFFS;
                end
                S_GAP: begin
                  rd_ptr <= rd_ptr + pkt_len;
                  seq    <= seq + 1'b1;
                  state  <= S_IDLE;
                end
                default: state <= S_IDLE;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
